// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS core: sequences fetch, decode, execute,
// memory and writeback states, and drives every datapath select and enable.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  state_t     state_q;
  state_t     state_d;
  logic       pcwrite;
  logic       branch;
  logic       branchne;
  logic       irwrite_raw;
  logic       regwrite_raw;
  logic       memwrite_raw;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_RTYPE:       state_d = EXECUTE;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_ADDI:        state_d = ADDIEX;
          OP_J:           state_d = JUMP;
          default:        state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Moore control outputs; write enables are gated by reset further down
  always_comb begin
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    aluop        = ALUOP_ADD;
    pcsrc        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    branchne     = 1'b0;
    case (state_q)
      FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb     = 2'b01;
        pcwrite     = 1'b1;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = 2'b01;
        branch   = (op == OP_BEQ);
        branchne = (op == OP_BNE);
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite_raw = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Unrecognised funct codes quietly fall back to add
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      ALUOP_SUB: alucontrol = 3'b110;
      ALUOP_FUNCT: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default:   alucontrol = 3'b010;
    endcase
  end

  assign irwrite  = ~reset & irwrite_raw;
  assign regwrite = ~reset & regwrite_raw;
  assign memwrite = ~reset & memwrite_raw;
  assign pcen     = ~reset & (pcwrite | (branch & zero) | (branchne & ~zero));
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle expectations are
// queued by the stimulus process and checked by an independent negedge monitor.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b111111;
  logic [5:0] funct = 6'b000000;
  logic       zero = 1'b0;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010, ILL = 6'b111111;
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11;
  localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110, A_AND = 3'b000, A_OR = 3'b001, A_SLT = 3'b111;

  typedef struct packed {
    logic [15:0] idx;
    logic [3:0]  st;
    logic [11:0] ctl;
    logic        alu_chk;
    logic [2:0]  alu;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   vec_idx = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen), .state(state)
  );

  always #5 clk = ~clk;

  // Packed as {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,pcen}
  function automatic logic [11:0] ctl_for(input logic [3:0] st, input logic r, input logic pe);
    logic [11:0] c;
    c = 12'h000;
    case (st)
      S_FETCH:  c = {1'b0, 1'b0, ~r, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, pe};
      S_DECODE: c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, pe};
      S_MEMADR: c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, pe};
      S_MEMRD:  c = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, pe};
      S_MEMWB:  c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ~r, 1'b0, 2'b00, 2'b00, pe};
      S_MEMWR:  c = {1'b1, ~r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, pe};
      S_EXEC:   c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, pe};
      S_ALUWB:  c = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ~r, 1'b0, 2'b00, 2'b00, pe};
      S_BRANCH: c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, pe};
      S_ADDIEX: c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, pe};
      S_ADDIWB: c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ~r, 1'b0, 2'b00, 2'b00, pe};
      S_JUMP:   c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, pe};
      default:  c = 12'h000;
    endcase
    return c;
  endfunction

  // One cycle: drive inputs just after the edge and queue what that cycle should show
  task automatic applyStimulus(input logic r, input logic [5:0] o, input logic [5:0] f,
                               input logic z, input logic [3:0] st, input logic pe,
                               input logic chk, input logic [2:0] alu);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r;
    op    = o;
    funct = f;
    zero  = z;
    e.idx     = 16'(vec_idx);
    e.st      = st;
    e.ctl     = ctl_for(st, r, pe);
    e.alu_chk = chk;
    e.alu     = alu;
    q.push_back(e);
    vec_idx++;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [11:0] act;
    act = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, pcen};
    tests++;
    if (state !== e.st) begin
      fails++;
      $display("[TB] FAIL state vec %0d: got %0d expected %0d", e.idx, state, e.st);
    end
    tests++;
    if (act !== e.ctl) begin
      fails++;
      $display("[TB] FAIL controls vec %0d (state %0d): got %b expected %b", e.idx, e.st, act, e.ctl);
    end
    if (e.alu_chk) begin
      tests++;
      if (alucontrol !== e.alu) begin
        fails++;
        $display("[TB] FAIL alucontrol vec %0d (state %0d): got %b expected %b", e.idx, e.st, alucontrol, e.alu);
      end
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) checkOutput(q.pop_front());
  end

  initial begin
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [5:0] fn [5];
    logic [2:0] ac [5];
    fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ac = '{A_ADD, A_SUB, A_AND, A_OR, A_SLT};

    applyStimulus(1, ILL, 6'd0, 0, S_FETCH, 0, 1, A_ADD);
    applyStimulus(1, ILL, 6'd0, 0, S_FETCH, 0, 1, A_ADD);

    // lw
    applyStimulus(0, LW, 6'd0, 0, S_FETCH,  1, 1, A_ADD);
    applyStimulus(0, LW, 6'd0, 0, S_DECODE, 0, 1, A_ADD);
    applyStimulus(0, LW, 6'd0, 0, S_MEMADR, 0, 1, A_ADD);
    applyStimulus(0, LW, 6'd0, 0, S_MEMRD,  0, 0, A_ADD);
    applyStimulus(0, LW, 6'd0, 0, S_MEMWB,  0, 0, A_ADD);

    // sw
    applyStimulus(0, SW, 6'd0, 0, S_FETCH,  1, 1, A_ADD);
    applyStimulus(0, SW, 6'd0, 0, S_DECODE, 0, 1, A_ADD);
    applyStimulus(0, SW, 6'd0, 0, S_MEMADR, 0, 1, A_ADD);
    applyStimulus(0, SW, 6'd0, 0, S_MEMWR,  0, 0, A_ADD);

    // R-type, each supported funct
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, RT, fn[i], 0, S_FETCH,  1, 1, A_ADD);
      applyStimulus(0, RT, fn[i], 0, S_DECODE, 0, 1, A_ADD);
      applyStimulus(0, RT, fn[i], 0, S_EXEC,   0, 1, ac[i]);
      applyStimulus(0, RT, fn[i], 0, S_ALUWB,  0, 0, A_ADD);
    end

    // unknown funct falls back to add
    applyStimulus(0, RT, 6'b000111, 0, S_FETCH,  1, 1, A_ADD);
    applyStimulus(0, RT, 6'b000111, 0, S_DECODE, 0, 1, A_ADD);
    applyStimulus(0, RT, 6'b000111, 0, S_EXEC,   0, 1, A_ADD);
    applyStimulus(0, RT, 6'b000111, 0, S_ALUWB,  0, 0, A_ADD);

    // addi
    applyStimulus(0, ADDI, 6'd0, 0, S_FETCH,  1, 1, A_ADD);
    applyStimulus(0, ADDI, 6'd0, 0, S_DECODE, 0, 1, A_ADD);
    applyStimulus(0, ADDI, 6'd0, 0, S_ADDIEX, 0, 1, A_ADD);
    applyStimulus(0, ADDI, 6'd0, 0, S_ADDIWB, 0, 0, A_ADD);

    // beq / bne with both zero values
    applyStimulus(0, BEQ, 6'd0, 1, S_FETCH,  1, 1, A_ADD);
    applyStimulus(0, BEQ, 6'd0, 1, S_DECODE, 0, 1, A_ADD);
    applyStimulus(0, BEQ, 6'd0, 1, S_BRANCH, 1, 1, A_SUB);
    applyStimulus(0, BEQ, 6'd0, 0, S_FETCH,  1, 1, A_ADD);
    applyStimulus(0, BEQ, 6'd0, 0, S_DECODE, 0, 1, A_ADD);
    applyStimulus(0, BEQ, 6'd0, 0, S_BRANCH, 0, 1, A_SUB);
    applyStimulus(0, BNE, 6'd0, 1, S_FETCH,  1, 1, A_ADD);
    applyStimulus(0, BNE, 6'd0, 1, S_DECODE, 0, 1, A_ADD);
    applyStimulus(0, BNE, 6'd0, 1, S_BRANCH, 0, 1, A_SUB);
    applyStimulus(0, BNE, 6'd0, 0, S_FETCH,  1, 1, A_ADD);
    applyStimulus(0, BNE, 6'd0, 0, S_DECODE, 0, 1, A_ADD);
    applyStimulus(0, BNE, 6'd0, 0, S_BRANCH, 1, 1, A_SUB);

    // j, then an illegal opcode
    applyStimulus(0, JMP, 6'd0, 0, S_FETCH,  1, 1, A_ADD);
    applyStimulus(0, JMP, 6'd0, 0, S_DECODE, 0, 1, A_ADD);
    applyStimulus(0, JMP, 6'd0, 0, S_JUMP,   1, 0, A_ADD);
    applyStimulus(0, ILL, 6'd0, 0, S_FETCH,  1, 1, A_ADD);
    applyStimulus(0, ILL, 6'd0, 0, S_DECODE, 0, 1, A_ADD);

    // reset held for three edges starting mid-EXECUTE
    applyStimulus(0, RT, 6'b100000, 0, S_FETCH,  1, 1, A_ADD);
    applyStimulus(0, RT, 6'b100000, 0, S_DECODE, 0, 1, A_ADD);
    applyStimulus(1, RT, 6'b100000, 0, S_EXEC,   0, 1, A_ADD);
    applyStimulus(1, RT, 6'b100000, 0, S_FETCH,  0, 1, A_ADD);
    applyStimulus(1, RT, 6'b100000, 0, S_FETCH,  0, 1, A_ADD);
    applyStimulus(0, ILL, 6'd0, 0, S_FETCH,  1, 1, A_ADD);
    applyStimulus(0, ILL, 6'd0, 0, S_DECODE, 0, 1, A_ADD);
    applyStimulus(0, ILL, 6'd0, 0, S_FETCH,  1, 1, A_ADD);

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d unchecked entries expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
